// File: rtl/mem_access_unit.sv
// Load/store bus sequencer: IDLE -> REQ -> DONE with ack timeout and sticky BusErr.
// Define MISALIGN_TRAP_EN to trap misaligned requests instead of word-aligning them.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
`ifdef MISALIGN_TRAP_EN
  output logic        MisalignErr,
`endif
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [7:0]  cnt;
  logic        req;
  logic        misal;
  logic        go;

  assign req = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign misal = |Addr[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = |Addr[1:0];
  assign misal = 1'b0;
`endif

  assign go        = req & ~misal;
  assign Stall     = (state == REQ) | ((state == IDLE) & go);
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ReadData <= 32'd0;
      BusErr   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
      if (state == IDLE && req && misal)
        MisalignErr <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (go) begin
            addr_q  <= {Addr[31:2], 2'b00};
            wdata_q <= WriteData;
            we_q    <= MemWrite;
            cnt     <= 8'd0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!we_q)
              ReadData <= bus_rdata;
            state <= DONE;
          end else if (cnt == LAST) begin
            // Timed-out reads return zero so stale data never reaches the datapath
            BusErr <= 1'b1;
            if (!we_q)
              ReadData <= 32'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ-state cycles allowed to wait for bus_ack (legal range 2..255).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-004 Port MemRead, input, 1, SHALL be the load request from the controller.
REQ-005 Port MemWrite, input, 1, SHALL be the store request from the controller.
REQ-006 Port Addr, input, 32, SHALL be the byte address taken from the datapath ALU result.
REQ-007 Port WriteData, input, 32, SHALL be the store data taken from the datapath register-file second read port.
REQ-008 Port ReadData, output, 32, SHALL be the registered load data fed to the datapath result mux.
REQ-009 Port Stall, output, 1, SHALL freeze the PC and register-file write while high.
REQ-010 Port BusErr, output, 1, SHALL be a sticky timeout flag.
REQ-011 Port MisalignErr, output, 1, SHALL be a one-cycle misaligned-access pulse (present only with MISALIGN_TRAP_EN).
REQ-012 Ports bus_req (out, 1), bus_we (out, 1), bus_addr (out, 32), bus_wdata (out, 32), bus_ack (in, 1) and bus_rdata (in, 32) SHALL form the memory-side handshake.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-014 IDLE with MemRead or MemWrite high SHALL:
- capture Addr, WriteData and the we bit (we = MemWrite) into registers;
- clear the wait counter;
- go to REQ on the next edge.
REQ-015 When MemRead and MemWrite are both high, the access SHALL be a write, and the read SHALL be ignored.
REQ-016 Stall SHALL be combinational: high in IDLE when a request is present, high throughout REQ, and low in DONE and in idle IDLE.
REQ-017 In REQ, bus_req SHALL be high and bus_addr, bus_wdata and bus_we SHALL be driven from the captured registers; in all other states bus_req SHALL be 0.
REQ-018 REQ with bus_ack high SHALL:
- load bus_rdata into ReadData (reads only; writes leave ReadData unchanged);
- go to DONE.
REQ-019 REQ without bus_ack SHALL increment the 8-bit wait counter; when the counter equals TIMEOUT-1, the block SHALL set BusErr, load ReadData with 32'h0 on reads, and go to DONE.
REQ-020 DONE SHALL last exactly one cycle, then return unconditionally to IDLE; a request seen in DONE SHALL NOT start a new access.
REQ-021 Minimum latency SHALL be 3 cycles from request to Stall low (IDLE, REQ with immediate ack, DONE).
REQ-022 Zero-wait ack SHALL be legal, and bus_ack outside REQ SHALL be ignored.
REQ-023 BusErr SHALL clear only on reset.

Reset
REQ-024 Asserting reset (low) at any time, including mid-REQ, SHALL immediately force:
- state to IDLE and the counter to 0;
- ReadData to 0 and BusErr to 0;
- bus_req to 0 and MisalignErr to 0.
REQ-025 After reset deasserts, the first accepted request SHALL start from IDLE with no stale captured data issued.

Configuration
REQ-026 With macro MISALIGN_TRAP_EN defined:
- a request with Addr[1:0] not equal to 0 SHALL produce no bus access;
- MisalignErr SHALL be high for that one cycle;
- Stall SHALL be low and the state SHALL remain IDLE.
REQ-027 With MISALIGN_TRAP_EN undefined, the MisalignErr port SHALL be absent and Addr[1:0] SHALL be forced to 0 on bus_addr (word-aligned access).

Verification
REQ-028 Read from Addr=0x100 with bus_ack in the first REQ cycle and bus_rdata=0xCAFEF00D -> Stall high 2 cycles, ReadData=0xCAFEF00D in DONE, bus_we=0.
REQ-029 Write to Addr=0x204 with WriteData=0x12345678 and ack after 3 wait cycles -> bus_we=1, bus_wdata=0x12345678, Stall high 5 cycles, ReadData unchanged.
REQ-030 Read with bus_ack never asserted and TIMEOUT=16 -> DONE after 16 REQ cycles, BusErr=1 and held, ReadData=0.
REQ-031 MemRead=MemWrite=1 at Addr=0x8 -> a single write access, bus_we=1.
REQ-032 Reset low during the 2nd REQ cycle -> bus_req=0 and Stall=0 immediately; a later read to 0x10 completes normally.
REQ-033 With MISALIGN_TRAP_EN defined, read at Addr=0x102 -> MisalignErr one-cycle pulse, bus_req stays 0, Stall stays 0.
